// File: rtl/mdu_sequencer_pkg.sv
// Operation codes and FSM states for the multiply/divide sequencer.
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    MDUOP_NONE  = 4'd0,
    MDUOP_MULT  = 4'd1,
    MDUOP_MULTU = 4'd2,
    MDUOP_DIV   = 4'd3,
    MDUOP_DIVU  = 4'd4,
    MDUOP_MTHI  = 4'd5,
    MDUOP_MTLO  = 4'd6,
    MDUOP_MFHI  = 4'd7,
    MDUOP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit with HI/LO: result computed at issue, committed after MULT_CYCLES/DIV_CYCLES.
// Busy holds off issue; starts while busy are dropped, MT* writes land on the next edge.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  mdu_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_pend, lo_pend;
  logic          pend_wr;

  logic               is_mul, is_div, calc_wr;
  logic [63:0]        calc;
  logic [31:0]        divisor;
  logic signed [31:0] sq, sr;

  // Full-width arithmetic; a zero divisor is replaced by 1 only to keep the divider defined.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    calc_wr = 1'b1;
    calc    = '0;
    divisor = (operand2 == '0) ? 32'd1 : operand2;
    sq      = $signed(operand1) / $signed(divisor);
    sr      = $signed(operand1) % $signed(divisor);
    if (operand1 == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
      sq = $signed(operand1);
      sr = '0;
    end
    case (op)
      MDUOP_MULT: begin
        is_mul = 1'b1;
        calc   = $signed({{32{operand1[31]}}, operand1}) * $signed({{32{operand2[31]}}, operand2});
      end
      MDUOP_MULTU: begin
        is_mul = 1'b1;
        calc   = {32'b0, operand1} * {32'b0, operand2};
      end
      MDUOP_DIV: begin
        is_div  = 1'b1;
        calc_wr = (operand2 != '0);
        calc    = {sr, sq};
      end
      MDUOP_DIVU: begin
        is_div  = 1'b1;
        calc_wr = (operand2 != '0);
        calc    = {operand1 % divisor, operand1 / divisor};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && (is_mul || is_div)) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (start && (is_mul || is_div)) begin
          {hi_pend, lo_pend} <= calc;
          pend_wr            <= calc_wr;
          cnt                <= is_mul ? MULT_LOAD : DIV_LOAD;
        end else if (start && op == MDUOP_MTHI) begin
          hi <= operand1;
        end else if (start && op == MDUOP_MTLO) begin
          lo <= operand1;
        end
      end else if (cnt == '0) begin
        // Divide-by-zero still occupies the unit but leaves HI/LO untouched.
        if (pend_wr) begin
          hi <= hi_pend;
          lo <= lo_pend;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (state == ST_RUN);

  always_comb begin
    result = '0;
    case (op)
      MDUOP_MFHI: result = hi;
      MDUOP_MFLO: result = lo;
      default: ;
    endcase
  end

endmodule
